monitor_verdict_serializer: RTL and testbench
=============================================

# monitor_verdict_serializer

Downstream stage of the generated monitor `topEntity`. It captures every cycle in which any monitor output stream is active (`output_k_aktv`) as a timestamped snapshot and buffers it in a snapshot FIFO. It then streams the active values one record at a time over a valid/ready interface to the trace sink. It replaces per-cycle `$display` sampling with a lossless-until-full hardware path and explicit overflow accounting.

## Interface
- `NUM_OUT`, default 6: number of monitor output streams.
- `DATA_W`, default 64: width of each signed output value.
- `TS_W`, default 32: timestamp counter width.
- `DEPTH`, default 16: snapshot FIFO depth; power of two, ≥2.
- `IDX_W`, default `$clog2(NUM_OUT)`, min 1: record index width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: **asynchronous, active-low reset**.
- `en` in 1: capture/timestamp enable, same signal as driven to the monitor.
- `out_data` in NUM_OUT*DATA_W: monitor outputs; stream k at bits [k*DATA_W +: DATA_W].
- `out_aktv` in NUM_OUT: per-stream active flags.
- `m_valid` out 1: record valid.
- `m_ready` in 1: sink ready.
- `m_index` out IDX_W: stream index of the record.
- `m_data` out DATA_W: stream value.
- `m_ts` out TS_W: timestamp of the source snapshot.
- `m_last` out 1: last record of its snapshot.
- `overflow` out 1: sticky, set on any dropped snapshot.
- `drop_count` out 16: dropped snapshots, saturating at 0xFFFF.
- `fifo_level` out $clog2(DEPTH)+1: occupied FIFO entries.

## Operation
- Timestamp counter `ts` resets to 0 and increments by 1 on every edge with `en`=1. It wraps modulo 2^TS_W and holds while `en`=0.
- **Capture.** On an edge with `en`=1 and `|out_aktv`, push the snapshot {out_aktv, out_data, ts} using the pre-increment `ts`.
  - Cycles with `en`=0 or all-zero `out_aktv` are never captured.
- **Full handling.** A push is accepted if `fifo_level`<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the snapshot is dropped: `overflow`←1 and `drop_count`+1 (saturating).
  - Buffered data is never overwritten.
- **Emitter FSM**, states IDLE and EMIT. The current snapshot register holds the remaining mask, values and ts.
  - IDLE → EMIT: FIFO non-empty. Pop the head into the current register on that edge.
  - In EMIT: `m_valid`=1; `m_index` = lowest set bit k of the remaining mask; `m_data` = value k; `m_ts` = snapshot ts.
  - `m_last`=1 when k is the only remaining set bit.
  - On `m_valid && m_ready`, clear bit k. If the cleared bit was the last one:
    - FIFO non-empty: pop the next snapshot on the same edge and stay in EMIT (no bubble).
    - FIFO empty: go to IDLE.
- Records are emitted in ascending index order. Snapshots are emitted in capture order.
- `en`=0 does not stall the emitter; draining continues.
- Simultaneous push and pop: both take effect and `fifo_level` is unchanged, including when the FIFO is full.
- Read and write pointers wrap modulo DEPTH.
- Reset, including mid-emission or mid-burst, clears the FIFO, the current snapshot, `ts`, `overflow` and `drop_count`. FSM → IDLE. In-flight records are discarded.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_index`=0, `m_data`=0, `m_ts`=0, `overflow`=0, `drop_count`=0, `fifo_level`=0.
- All outputs are registered or decoded from registers only. No combinational path from `m_ready` or `out_aktv` to any output.
- Latency, empty FIFO and IDLE emitter: snapshot written at edge N, popped at edge N+1. `m_valid` is high after N+1, for 2 cycles from the capture edge.
- Throughput: one record per cycle under `m_ready`=1, across snapshot boundaries.
- While `m_valid`=1 and `m_ready`=0, `m_index`, `m_data`, `m_ts` and `m_last` are held stable.
- `fifo_level` reflects state after each edge. It does not count the snapshot held in the current register.

## Test plan
1. Only stream 2 active (value 5) at ts=500, `m_ready`=1 → one record {index 2, data 5, ts 500, last 1}, `m_valid` 2 cycles after capture.
2. Mask 0b101001, values 1/-3/7 on streams 0/3/5, `m_ready`=1 → records index 0,3,5 on consecutive cycles, data 1,-3,7, `m_last` only on index 5, equal ts.
3. Five single-stream snapshots on consecutive cycles, `m_ready`=1 → five records back-to-back with no bubble, ts strictly increasing by 1.
4. DEPTH=4, `m_ready`=0, seven consecutive captures → 4 buffered, the current register loads from the first pop, and captures are dropped at full. Expect `drop_count` to reach 2, `overflow`=1 and outputs held stable; releasing `m_ready` drains the 5 retained snapshots in order.
5. Assert `rst`=0 mid-snapshot (after 1 of 3 records) → `m_valid` falls immediately and all counters are 0. After release the next capture is emitted with ts counting from 0.
6. `en`=0 for 10 cycles with `out_aktv` set and one snapshot pending → no new captures and `ts` frozen. The pending snapshot still drains, and ts resumes from its held value.

Source files
------------

// File: rtl/monitor_verdict_serializer_if.sv
// -----------------------------------------------------------------------------
// monitor_verdict_serializer_if
// Record stream from the verdict serializer to the trace sink.
//   m_valid : record valid (driven by master)
//   m_ready : sink ready   (driven by slave)
//   m_index : stream index of the record
//   m_data  : signed stream value
//   m_ts    : timestamp of the snapshot the record came from
//   m_last  : last record of its snapshot
// -----------------------------------------------------------------------------
interface monitor_verdict_serializer_if #(
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int IDX_W  = 3
);
    logic              m_valid;
    logic              m_ready;
    logic [IDX_W-1:0]  m_index;
    logic [DATA_W-1:0] m_data;
    logic [TS_W-1:0]   m_ts;
    logic              m_last;

    modport master (
        output m_valid,
        output m_index,
        output m_data,
        output m_ts,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_index,
        input  m_data,
        input  m_ts,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/monitor_verdict_serializer.sv
// -----------------------------------------------------------------------------
// monitor_verdict_serializer
// Captures every enabled cycle in which any monitor output stream is active as
// a timestamped snapshot, buffers it in a snapshot FIFO and emits the active
// values one record per cycle over a valid/ready stream. Snapshots that find
// the FIFO full are dropped and counted; buffered data is never overwritten.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   en         : capture / timestamp enable
//   out_data   : monitor outputs, stream k at [k*DATA_W +: DATA_W]
//   out_aktv   : per-stream active flags
//   m_if       : record stream (master side)
//   overflow   : sticky, set when any snapshot is dropped
//   drop_count : dropped snapshots, saturating at 16'hFFFF
//   fifo_level : buffered snapshots (excludes the one being emitted)
// -----------------------------------------------------------------------------
module monitor_verdict_serializer #(
    parameter int NUM_OUT = 6,
    parameter int DATA_W  = 64,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 16,
    parameter int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_OUT*DATA_W-1:0]   out_data,
    input  logic [NUM_OUT-1:0]          out_aktv,
    monitor_verdict_serializer_if.master m_if,
    output logic                        overflow,
    output logic [15:0]                 drop_count,
    output logic [$clog2(DEPTH):0]      fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_OUT-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            idx = mask[k] ? IDX_W'(k) : idx;
        end
        return idx;
    endfunction

    // True when exactly one bit of the mask is set.
    function automatic logic is_single(input logic [NUM_OUT-1:0] mask);
        return (mask != {NUM_OUT{1'b0}}) &&
               ((mask & (mask - {{(NUM_OUT-1){1'b0}}, 1'b1})) == {NUM_OUT{1'b0}});
    endfunction

    // Stream value selected by index.
    function automatic logic [DATA_W-1:0] select_value(input logic [NUM_OUT*DATA_W-1:0] vals,
                                                       input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_OUT; k++) begin
            v = (idx == IDX_W'(k)) ? vals[k*DATA_W +: DATA_W] : v;
        end
        return v;
    endfunction

    // Snapshot storage
    logic [NUM_OUT-1:0]        r_mem_mask [DEPTH];
    logic [NUM_OUT*DATA_W-1:0] r_mem_data [DEPTH];
    logic [TS_W-1:0]           r_mem_ts   [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [LW-1:0]             r_level;

    logic [TS_W-1:0]           r_ts;
    logic                      r_overflow;
    logic [15:0]               r_drop_count;

    // Current snapshot and emitter state
    state_t                    r_state;
    logic [NUM_OUT-1:0]        r_cur_mask;
    logic [NUM_OUT*DATA_W-1:0] r_cur_data;
    logic [TS_W-1:0]           r_cur_ts;

    // Registered record outputs
    logic                      r_m_valid;
    logic [IDX_W-1:0]          r_m_index;
    logic [DATA_W-1:0]         r_m_data;
    logic [TS_W-1:0]           r_m_ts;
    logic                      r_m_last;

    logic                      w_empty;
    logic                      w_full;
    logic                      w_fire;
    logic [NUM_OUT-1:0]        w_mask_rest;
    logic                      w_cap_req;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_pop;
    state_t                    w_nxt_state;
    logic [NUM_OUT-1:0]        w_nxt_mask;
    logic [NUM_OUT*DATA_W-1:0] w_nxt_data;
    logic [TS_W-1:0]           w_nxt_ts;
    logic [IDX_W-1:0]          w_nxt_idx;

    assign w_empty     = (r_level == {LW{1'b0}});
    assign w_full      = (r_level == DEPTH_L);
    assign w_fire      = (r_state == ST_EMIT) && m_if.m_ready;
    // Clearing the lowest set bit retires the record currently presented.
    assign w_mask_rest = r_cur_mask & (r_cur_mask - {{(NUM_OUT-1){1'b0}}, 1'b1});
    assign w_cap_req   = en && (|out_aktv);
    // A full FIFO still accepts when the emitter pops on the same edge.
    assign w_push      = w_cap_req && (!w_full || w_pop);
    assign w_drop      = w_cap_req && !w_push;

    // Emitter next-state, pop request and next current-snapshot contents
    always_comb begin
        w_nxt_state = r_state;
        w_pop       = 1'b0;
        w_nxt_mask  = r_cur_mask;
        w_nxt_data  = r_cur_data;
        w_nxt_ts    = r_cur_ts;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nxt_state = ST_EMIT;
                    w_nxt_mask  = r_mem_mask[r_rd_ptr];
                    w_nxt_data  = r_mem_data[r_rd_ptr];
                    w_nxt_ts    = r_mem_ts[r_rd_ptr];
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (w_fire) begin
                    if (w_mask_rest == {NUM_OUT{1'b0}}) begin
                        // Snapshot finished: chain straight into the next one.
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_nxt_state = ST_EMIT;
                            w_nxt_mask  = r_mem_mask[r_rd_ptr];
                            w_nxt_data  = r_mem_data[r_rd_ptr];
                            w_nxt_ts    = r_mem_ts[r_rd_ptr];
                        end else begin
                            w_nxt_state = ST_IDLE;
                            w_nxt_mask  = {NUM_OUT{1'b0}};
                        end
                    end else begin
                        w_nxt_mask = w_mask_rest;
                    end
                end else begin
                    w_nxt_state = ST_EMIT;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_mask  = {NUM_OUT{1'b0}};
            end
        endcase
    end

    assign w_nxt_idx = lowest_idx(w_nxt_mask);

    // Timestamp counter and drop accounting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts         <= {TS_W{1'b0}};
            r_overflow   <= 1'b0;
            r_drop_count <= 16'h0000;
        end else begin
            if (en) begin
                r_ts <= r_ts + {{(TS_W-1){1'b0}}, 1'b1};
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'h0001;
                end
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   r_level <= r_level - {{(LW-1){1'b0}}, 1'b1};
                default: r_level <= r_level;
            endcase
        end
    end

    // Snapshot storage write; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_mask[r_wr_ptr] <= out_aktv;
            r_mem_data[r_wr_ptr] <= out_data;
            r_mem_ts[r_wr_ptr]   <= r_ts;
        end
    end

    // Emitter state and current snapshot register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cur_mask <= {NUM_OUT{1'b0}};
            r_cur_data <= {(NUM_OUT*DATA_W){1'b0}};
            r_cur_ts   <= {TS_W{1'b0}};
        end else begin
            r_state    <= w_nxt_state;
            r_cur_mask <= w_nxt_mask;
            r_cur_data <= w_nxt_data;
            r_cur_ts   <= w_nxt_ts;
        end
    end

    // Record output registers, zeroed while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_valid <= 1'b0;
            r_m_index <= {IDX_W{1'b0}};
            r_m_data  <= {DATA_W{1'b0}};
            r_m_ts    <= {TS_W{1'b0}};
            r_m_last  <= 1'b0;
        end else if (w_nxt_state == ST_EMIT) begin
            r_m_valid <= 1'b1;
            r_m_index <= w_nxt_idx;
            r_m_data  <= select_value(w_nxt_data, w_nxt_idx);
            r_m_ts    <= w_nxt_ts;
            r_m_last  <= is_single(w_nxt_mask);
        end else begin
            r_m_valid <= 1'b0;
            r_m_index <= {IDX_W{1'b0}};
            r_m_data  <= {DATA_W{1'b0}};
            r_m_ts    <= {TS_W{1'b0}};
            r_m_last  <= 1'b0;
        end
    end

    assign m_if.m_valid = r_m_valid;
    assign m_if.m_index = r_m_index;
    assign m_if.m_data  = r_m_data;
    assign m_if.m_ts    = r_m_ts;
    assign m_if.m_last  = r_m_last;
    assign overflow     = r_overflow;
    assign drop_count   = r_drop_count;
    assign fifo_level   = r_level;

endmodule

// File: tb/tb_monitor_verdict_serializer.sv
module tb_monitor_verdict_serializer;
    localparam int NUM_OUT = 6;
    localparam int DATA_W  = 64;
    localparam int TS_W    = 32;
    localparam int DEPTH   = 4;
    localparam int IDX_W   = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]        out_aktv;
    logic                      overflow;
    logic [15:0]               drop_count;
    logic [2:0]                fifo_level;

    int vectors = 0;
    int miscompares = 0;

    monitor_verdict_serializer_if #(.DATA_W(DATA_W), .TS_W(TS_W), .IDX_W(IDX_W)) m_if ();

    monitor_verdict_serializer #(
        .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH), .IDX_W(IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out_data   (out_data),
        .out_aktv   (out_aktv),
        .m_if       (m_if),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_val(input int k, input logic [63:0] v);
        out_data[k*DATA_W +: DATA_W] = v;
    endtask

    task automatic chk_rec(input string tag, input logic [63:0] idx, input logic [63:0] data,
                           input logic [63:0] ts, input logic [63:0] last);
        chk({tag, ".valid"}, 64'(m_if.m_valid), 64'd1);
        chk({tag, ".index"}, 64'(m_if.m_index), idx);
        chk({tag, ".data"},  m_if.m_data, data);
        chk({tag, ".ts"},    64'(m_if.m_ts), ts);
        chk({tag, ".last"},  64'(m_if.m_last), last);
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        out_data = '0;
        out_aktv = 6'b000000;
        m_if.m_ready = 1'b1;
        tick();
        tick();
        chk("rst.valid", 64'(m_if.m_valid), 64'd0);
        chk("rst.last",  64'(m_if.m_last), 64'd0);
        chk("rst.index", 64'(m_if.m_index), 64'd0);
        chk("rst.data",  m_if.m_data, 64'd0);
        chk("rst.ts",    64'(m_if.m_ts), 64'd0);
        chk("rst.ovf",   64'(overflow), 64'd0);
        chk("rst.drop",  64'(drop_count), 64'd0);
        chk("rst.level", 64'(fifo_level), 64'd0);
        rst = 1'b1;

        // 1: single stream at ts 500
        en = 1'b1;
        repeat (500) tick();
        out_aktv = 6'b000100;
        set_val(2, 64'd5);
        tick();
        en = 1'b0;
        out_aktv = 6'b000000;
        chk("t1.valid_n", 64'(m_if.m_valid), 64'd0);
        chk("t1.level",   64'(fifo_level), 64'd1);
        tick();
        chk_rec("t1", 64'd2, 64'd5, 64'd500, 64'd1);
        chk("t1.level0", 64'(fifo_level), 64'd0);
        tick();
        chk("t1.idle", 64'(m_if.m_valid), 64'd0);

        // 2: three streams, one snapshot at ts 501
        out_data = '0;
        en = 1'b1;
        out_aktv = 6'b101001;
        set_val(0, 64'd1);
        set_val(3, 64'hFFFF_FFFF_FFFF_FFFD);
        set_val(5, 64'd7);
        tick();
        en = 1'b0;
        out_aktv = 6'b000000;
        tick();
        chk_rec("t2.r0", 64'd0, 64'd1, 64'd501, 64'd0);
        tick();
        chk_rec("t2.r1", 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd501, 64'd0);
        tick();
        chk_rec("t2.r2", 64'd5, 64'd7, 64'd501, 64'd1);
        tick();
        chk("t2.idle", 64'(m_if.m_valid), 64'd0);

        // 3: five consecutive snapshots, ts 502..506, back to back
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            out_data = '0;
            out_aktv = 6'b000001 << i;
            set_val(i, 64'd10 + 64'(i));
            tick();
            if (i > 0) begin
                chk("t3.valid", 64'(m_if.m_valid), 64'd1);
                chk("t3.index", 64'(m_if.m_index), 64'(i - 1));
                chk("t3.ts",    64'(m_if.m_ts), 64'd502 + 64'(i - 1));
            end
        end
        en = 1'b0;
        out_aktv = 6'b000000;
        tick();
        chk_rec("t3.r4", 64'd4, 64'd14, 64'd506, 64'd1);
        tick();
        chk("t3.idle", 64'(m_if.m_valid), 64'd0);

        // 4: overflow with sink stalled, captures at ts 507..513
        m_if.m_ready = 1'b0;
        en = 1'b1;
        for (int j = 0; j < 7; j++) begin
            out_data = '0;
            out_aktv = 6'b000001 << (j % 6);
            set_val(j % 6, 64'd100 + 64'(j));
            tick();
            if (j == 1) chk_rec("t4.first", 64'd0, 64'd100, 64'd507, 64'd1);
            if (j == 4) begin
                chk("t4.level4", 64'(fifo_level), 64'd4);
                chk("t4.drop0",  64'(drop_count), 64'd0);
            end
            if (j == 5) chk("t4.drop1", 64'(drop_count), 64'd1);
        end
        en = 1'b0;
        out_aktv = 6'b000000;
        chk("t4.drop2", 64'(drop_count), 64'd2);
        chk("t4.ovf",   64'(overflow), 64'd1);
        chk("t4.level", 64'(fifo_level), 64'd4);
        chk_rec("t4.held", 64'd0, 64'd100, 64'd507, 64'd1);
        m_if.m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk_rec("t4.drain", 64'(k), 64'd100 + 64'(k), 64'd507 + 64'(k), 64'd1);
            tick();
        end
        chk("t4.idle",   64'(m_if.m_valid), 64'd0);
        chk("t4.empty",  64'(fifo_level), 64'd0);
        chk("t4.sticky", 64'(overflow), 64'd1);

        // 5: reset after 1 of 3 records
        out_data = '0;
        en = 1'b1;
        out_aktv = 6'b000111;
        set_val(0, 64'd1);
        set_val(1, 64'd2);
        set_val(2, 64'd3);
        tick();
        en = 1'b0;
        out_aktv = 6'b000000;
        tick();
        chk("t5.r0", 64'(m_if.m_index), 64'd0);
        tick();
        chk("t5.r1", 64'(m_if.m_index), 64'd1);
        rst = 1'b0;
        #1;
        chk("t5.valid", 64'(m_if.m_valid), 64'd0);
        chk("t5.index", 64'(m_if.m_index), 64'd0);
        chk("t5.ovf",   64'(overflow), 64'd0);
        chk("t5.drop",  64'(drop_count), 64'd0);
        chk("t5.level", 64'(fifo_level), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        out_data = '0;
        en = 1'b1;
        out_aktv = 6'b010000;
        set_val(4, 64'd44);
        tick();
        en = 1'b0;
        out_aktv = 6'b000000;
        tick();
        chk_rec("t5.post", 64'd4, 64'd44, 64'd0, 64'd1);
        tick();
        chk("t5.idle", 64'(m_if.m_valid), 64'd0);

        // 6: en low with streams active, pending snapshot still drains
        out_data = '0;
        en = 1'b1;
        out_aktv = 6'b000010;
        set_val(1, 64'd77);
        tick();
        en = 1'b0;
        out_aktv = 6'b111111;
        tick();
        chk_rec("t6.pend", 64'd1, 64'd77, 64'd1, 64'd1);
        repeat (9) tick();
        chk("t6.idle",  64'(m_if.m_valid), 64'd0);
        chk("t6.level", 64'(fifo_level), 64'd0);
        chk("t6.drop",  64'(drop_count), 64'd0);
        out_data = '0;
        en = 1'b1;
        out_aktv = 6'b100000;
        set_val(5, 64'd9);
        tick();
        en = 1'b0;
        out_aktv = 6'b000000;
        tick();
        chk_rec("t6.resume", 64'd5, 64'd9, 64'd2, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
